// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit
//   Iterative RV32M/RV64M multiply/divide unit that sits beside the single-cycle
//   ALU. It decodes ALUOp/funct7/funct3 the same way the ALU controller does and
//   runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over several cycles. Valid/ready
//   handshakes on both sides let the datapath stall while the unit is busy.
//
//   Optional feature macro: MULDIV_FAST_MUL_EN
//     defined   : every MUL* op uses a single-cycle '*' and goes straight to DONE
//     undefined : shift-add multiply, one multiplier bit per cycle, no '*' inferred
//
// Ports
//   clk        in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   flush      in   1     synchronous abort of any in-flight op
//   in_valid   in   1     request valid
//   in_ready   out  1     unit can accept a request (IDLE only)
//   alu_op     in   2     controller ALUOp (2'b10 = R/I-type)
//   funct7     in   7     instr[31:25]
//   funct3     in   3     instr[14:12], selects the M operation
//   src_a      in   XLEN  rs1 value
//   src_b      in   XLEN  rs2 value
//   is_muldiv  out  1     combinational M-extension decode
//   out_valid  out  1     result valid (DONE only)
//   out_ready  in   1     consumer takes the result
//   result     out  XLEN  operation result, held until the out handshake

module muldiv_seq_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            is_muldiv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              a_signed, b_signed, neg_d;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, is_special;
  logic [XLEN-1:0]   special_val;

  assign is_muldiv = (alu_op == 2'b10) && (funct7 == 7'b0000001);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready && is_muldiv && !flush;

  // Operand signedness and result sign per funct3. The core always works on
  // magnitudes, so the sign to re-apply is captured here at accept time.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    neg_d    = 1'b0;
    case (funct3)
      3'b001: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_d    = src_a[XLEN-1] ^ src_b[XLEN-1];
      end
      3'b010: begin
        a_signed = 1'b1;
        neg_d    = src_a[XLEN-1];
      end
      3'b100: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_d    = src_a[XLEN-1] ^ src_b[XLEN-1];
      end
      3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_d    = src_a[XLEN-1];
      end
      default: ;
    endcase
  end

  assign mag_a = (a_signed && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b = (b_signed && src_b[XLEN-1]) ? -src_b : src_b;

  // Divide-by-zero and signed overflow have fixed answers and skip the divider.
  assign div_zero    = (src_b == '0);
  assign div_ovf     = funct3[2] && !funct3[0] && (src_a == MIN_VAL) && (src_b == '1);
  assign is_special  = funct3[2] && (div_zero || div_ovf);
  assign special_val = div_zero ? (funct3[1] ? src_a : '1)
                                : (funct3[1] ? '0 : MIN_VAL);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Sign-extending to 2*XLEN makes a plain unsigned product correct for all
  // four multiply flavours.
  assign fast_a    = {{XLEN{a_signed & src_a[XLEN-1]}}, src_a};
  assign fast_b    = {{XLEN{b_signed & src_b[XLEN-1]}}, src_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                            : fast_prod[2*XLEN-1:XLEN];
`endif

  // Shift-add step: acc holds {partial high, remaining multiplier bits}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, mul_prod;
  logic [XLEN-1:0]   mul_final;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod  = neg_q ? -mul_step : mul_step;
  assign mul_final = (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Restoring step: acc holds {partial remainder, dividend/quotient bits}.
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_n, div_val, div_final;
  logic [2*XLEN-1:0] div_step;

  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem_n = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
  assign div_step  = {div_rem_n, acc_q[XLEN-2:0], div_ge};
  assign div_val   = op_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
  assign div_final = neg_q ? -div_val : div_val;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state. The last iteration writes the result, so DONE follows it
  // directly; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (funct3[2])
            state_d = is_special ? DONE : DIV;
          else
`ifdef MULDIV_FAST_MUL_EN
            state_d = DONE;
`else
            state_d = MUL;
`endif
        end
      end
      MUL:     if (cnt_q == LAST_CNT) state_d = DONE;
      DIV:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath. Nothing is written during flush so result keeps its old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3[1:0];
            neg_q <= neg_d;
            cnt_q <= '0;
            if (funct3[2]) begin
              opb_q <= mag_b;
              acc_q <= {{XLEN{1'b0}}, mag_a};
              if (is_special) result_q <= special_val;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_q <= fast_res;
`else
              opb_q <= mag_a;
              acc_q <= {{XLEN{1'b0}}, mag_b};
`endif
            end
          end
        end
        MUL: begin
          acc_q <= mul_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) result_q <= mul_final;
        end
        DIV: begin
          acc_q <= div_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) result_q <= div_final;
        end
        default: ;
      endcase
    end
  end

endmodule
